// File: rtl/mm_pkg.sv
// Shared definitions for the 2x2 matrix-multiply core and its stream sequencer.
package mm_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned RES_W_DEF  = 17;
    localparam int unsigned N_OPERANDS = 8;
    localparam int unsigned N_RESULTS  = 4;
    localparam int unsigned CNT_W      = $clog2(N_OPERANDS);
    localparam int unsigned IDX_W      = $clog2(N_RESULTS);
    localparam int unsigned LAT_W      = 4;

    typedef enum logic [2:0] {
        LOAD,
        FLUSH,
        EXEC,
        WAIT,
        SETUP,
        DRAIN
    } state_e;

endpackage

// File: rtl/mm_stream_sequencer.sv
// Handshaked front end for the 2x2 matmul core: loads an 8-byte operand frame,
// strobes execute, then streams the four results out in C00, C01, C10, C11 order.
module mm_stream_sequencer
    import mm_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RES_W    = RES_W_DEF,
    parameter int unsigned EXEC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [CNT_W-1:0]  sel_in,
    output logic [DATA_W-1:0] input_val,
    output logic              execute,
    output logic [IDX_W-1:0]  sel_out,
    input  logic [RES_W-1:0]  result,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPERANDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RESULTS - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(EXEC_LAT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LAT_W-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0]    sel_in_q, sel_in_d;
    logic [DATA_W-1:0]   input_val_q, input_val_d;
    logic [IDX_W-1:0]    sel_out_q, sel_out_d;
    logic                out_valid_q, out_valid_d;
    logic [RES_W-1:0]    out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                execute_q, execute_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                frame_err_q, frame_err_d;

    logic                in_hs;
    logic                out_hs;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            sel_in_q    <= '0;
            input_val_q <= '0;
            sel_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            execute_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            sel_in_q    <= sel_in_d;
            input_val_q <= input_val_d;
            sel_out_q   <= sel_out_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            execute_q   <= execute_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        sel_in_d    = sel_in_q;
        input_val_d = input_val_q;
        sel_out_d   = sel_out_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    sel_in_d    = cnt_q;
                    input_val_d = in_data;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (in_last) begin
                            state_d = EXEC;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = FLUSH;
                        end
                    end else if (in_last) begin
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                // Overlong frame: swallow bytes up to its in_last without touching the core
                if (in_hs && in_last) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            EXEC: begin
                wait_d  = LAT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == '0) begin
                    idx_d     = '0;
                    sel_out_d = '0;
                    state_d   = SETUP;
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end
            SETUP: begin
                out_data_d  = result;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LAST_IDX);
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    if (idx_q != LAST_IDX) begin
                        idx_d     = idx_q + IDX_W'(1);
                        sel_out_d = idx_q + IDX_W'(1);
                        state_d   = SETUP;
                    end else begin
                        out_last_d = 1'b0;
                        sel_out_d  = '0;
                        state_d    = LOAD;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Strobes decoded from the upcoming state so they register in step with it
        execute_d  = (state_d == EXEC);
        in_ready_d = (state_d == LOAD) || (state_d == FLUSH);
        busy_d     = (state_d != LOAD);
    end

    assign in_ready  = in_ready_q;
    assign sel_in    = sel_in_q;
    assign input_val = input_val_q;
    assign execute   = execute_q;
    assign sel_out   = sel_out_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mm_stream_sequencer.sv
// Bench for mm_stream_sequencer with a behavioural 2x2 matmul core attached.
module tb_mm_stream_sequencer;

    localparam int unsigned EXEC_LAT = 2;

    typedef logic [0:7][7:0]  frame_t;
    typedef logic [0:3][16:0] res_t;

    typedef struct packed {
        frame_t b;
        res_t   c;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [2:0]  sel_in;
    logic [7:0]  input_val;
    logic        execute;
    logic [1:0]  sel_out;
    logic [16:0] result;
    logic        out_valid;
    logic [16:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int exec_cnt = 0;
    int err_cnt = 0;
    logic [17:0] got_q[$];

    always #5 clk = ~clk;

    mm_stream_sequencer #(.DATA_W(8), .RES_W(17), .EXEC_LAT(EXEC_LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .sel_in(sel_in), .input_val(input_val), .execute(execute),
        .sel_out(sel_out), .result(result),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .frame_err(frame_err)
    );

    // Core model: operand slots written from sel_in/input_val, result = (A*B)[sel_out]
    logic [7:0] slot [8];
    always @(posedge clk) slot[sel_in] <= input_val;
    always_comb begin
        result = 17'(slot[{1'b0, sel_out[1], 1'b0}]) * 17'(slot[{1'b1, 1'b0, sel_out[0]}])
               + 17'(slot[{1'b0, sel_out[1], 1'b1}]) * 17'(slot[{1'b1, 1'b1, sel_out[0]}]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [16:0] mat_c(input frame_t b, input int r, input int c);
        int acc = 0;
        for (int k = 0; k < 2; k++) acc += int'(b[r*2 + k]) * int'(b[4 + k*2 + c]);
        return 17'(acc);
    endfunction

    always @(negedge clk) begin
        if (execute) exec_cnt++;
        if (frame_err) err_cnt++;
    end

    // Downstream sink: drives out_ready, records words, checks hold-while-stalled
    int          stall = 0;
    int          frame_word = 0;
    logic        prev_stalled = 1'b0;
    logic [16:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (out_valid && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                end else out_ready = out_valid;
            end
            default: out_ready = 1'b0;
        endcase
        if (reset) begin
            frame_word   = 0;
            prev_stalled = 1'b0;
            stall        = 0;
        end else begin
            if (prev_stalled && out_valid) begin
                chk("stall_data_hold", 32'(out_data), 32'(prev_data));
                chk("stall_last_hold", 32'(out_last), 32'(prev_last));
            end
            if (out_valid) chk("sel_out_index", 32'(sel_out), 32'(frame_word));
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                frame_word   = (frame_word + 1) % 4;
                stall        = 0;
                prev_stalled = 1'b0;
            end else if (out_valid) begin
                prev_stalled = 1'b1;
                prev_data    = out_data;
                prev_last    = out_last;
            end else prev_stalled = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input frame_t b);
        for (int i = 0; i < 8; i++) send_byte(b[i], i == 7);
    endtask

    task automatic expect_words(input res_t c, input string tag);
        int t = 0;
        logic [17:0] w;
        while (got_q.size() < 4 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (got_q.size() < 4) begin
            chk({tag, "_word_timeout"}, 32'(got_q.size()), 32'd4);
            got_q.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                w = got_q.pop_front();
                chk({tag, "_data"}, 32'(w[16:0]), 32'(c[k]));
                chk({tag, "_last"}, 32'(w[17]), 32'(k == 3));
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_execute"}, 32'(execute), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_sel_out"}, 32'(sel_out), 32'd0);
        chk({tag, "_sel_in"}, 32'(sel_in), 32'd0);
        chk({tag, "_input_val"}, 32'(input_val), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        vec_t   tbl [4];
        frame_t rb;
        res_t   ec;
        int     e0, f0, n, len;

        tbl[0].b = {8'h01, 8'h02, 8'h00, 8'h03, 8'h03, 8'h01, 8'h02, 8'h01};
        tbl[0].c = {17'd7, 17'd3, 17'd6, 17'd3};
        tbl[1].b = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[1].c = {17'h1FC02, 17'h1FC02, 17'h1FC02, 17'h1FC02};
        tbl[2].b = {8'h01, 8'h00, 8'h00, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08};
        tbl[2].c = {17'd5, 17'd6, 17'd7, 17'd8};
        tbl[3].b = {8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        tbl[3].c = {17'd36, 17'd41, 17'd64, 17'd73};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        // Table-driven nominal frames
        for (int t = 0; t < 4; t++) begin
            e0 = exec_cnt; f0 = err_cnt;
            send_frame(tbl[t].b);
            expect_words(tbl[t].c, "table");
            repeat (2) @(negedge clk);
            chk("table_exec_pulses", 32'(exec_cnt - e0), 32'd1);
            chk("table_frame_err", 32'(err_cnt - f0), 32'd0);
            chk("table_in_ready_after", 32'(in_ready), 32'd1);
            chk("table_busy_after", 32'(busy), 32'd0);
        end

        // Latency from EXEC entry to first out_valid
        send_frame(tbl[0].b);
        chk("exec_strobe", 32'(execute), 32'd1);
        chk("exec_in_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency", 32'(n), 32'(EXEC_LAT + 2));
        expect_words(tbl[0].c, "latency");

        // Backpressure: five stalled cycles on every word
        mode = 2;
        send_frame(tbl[1].b);
        expect_words(tbl[1].c, "bp");
        repeat (2) @(negedge clk);
        mode = 0;

        // Short frame: in_last on byte 4
        e0 = exec_cnt; f0 = err_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'(i + 9), i == 3);
        chk("short_err_pulse", 32'(frame_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("short_err_count", 32'(err_cnt - f0), 32'd1);
        chk("short_no_exec", 32'(exec_cnt - e0), 32'd0);
        chk("short_no_words", 32'(got_q.size()), 32'd0);
        send_frame(tbl[2].b);
        expect_words(tbl[2].c, "after_short");

        // Long frame: 10 bytes, error flagged on byte 8, rest flushed
        repeat (2) @(negedge clk);
        e0 = exec_cnt; f0 = err_cnt;
        for (int i = 0; i < 10; i++) begin
            send_byte(8'($urandom), i == 9);
            if (i == 7) begin
                chk("long_err_at_byte8", 32'(frame_err), 32'd1);
                chk("long_flush_ready", 32'(in_ready), 32'd1);
            end
        end
        repeat (3) @(negedge clk);
        chk("long_err_count", 32'(err_cnt - f0), 32'd1);
        chk("long_no_exec", 32'(exec_cnt - e0), 32'd0);
        chk("long_no_words", 32'(got_q.size()), 32'd0);
        send_frame(tbl[3].b);
        expect_words(tbl[3].c, "after_long");

        // Reset during WAIT
        repeat (2) @(negedge clk);
        send_frame(tbl[1].b);
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_no_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_wait");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset during DRAIN with the sink holding off
        mode = 3;
        send_frame(tbl[0].b);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_reached", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_drain");
        @(negedge clk);
        reset = 1'b0;
        mode = 0;
        @(negedge clk);
        chk("post_reset_no_words", 32'(got_q.size()), 32'd0);
        send_frame(tbl[3].b);
        expect_words(tbl[3].c, "post_reset");
        repeat (10) @(negedge clk);
        chk("post_reset_no_stray", 32'(got_q.size()), 32'd0);

        // Randomised frames against the matrix model
        mode = 1;
        for (int f = 0; f < 40; f++) begin
            n  = $urandom_range(0, 9);
            e0 = exec_cnt; f0 = err_cnt;
            if (n < 7) begin
                for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
                for (int k = 0; k < 4; k++) ec[k] = mat_c(rb, k / 2, k % 2);
                send_frame(rb);
                expect_words(ec, "rand");
                chk("rand_exec", 32'(exec_cnt - e0), 32'd1);
                chk("rand_no_err", 32'(err_cnt - f0), 32'd0);
            end else begin
                len = (n == 7) ? $urandom_range(1, 7) : $urandom_range(9, 12);
                for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1);
                repeat (2) @(negedge clk);
                chk("rand_bad_err", 32'(err_cnt - f0), 32'd1);
                chk("rand_bad_no_exec", 32'(exec_cnt - e0), 32'd0);
                chk("rand_bad_no_words", 32'(got_q.size()), 32'd0);
            end
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mm_stream_sequencer.md
Name: mm_stream_sequencer

Overview:
- Upstream/downstream controller for the 2x2 matrix-multiply core (8-bit operands, 17-bit results).
- Accepts an 8-byte operand frame on a valid/ready byte stream and writes each byte into the core via sel_in/input_val.
- Pulses execute, waits a fixed latency, then sweeps sel_out 0..3 and returns the four results on a valid/ready output stream.
- Replaces testbench-style timed driving of the core with a handshaked interface.

Parameters:
- DATA_W, 8, operand byte width (matches core input_val).
- RES_W, 17, result width (matches core result).
- EXEC_LAT, 2, cycles after the execute pulse before result is valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand byte valid.
- in_data  in  DATA_W  operand byte. Bytes 0-3 are matrix A row-major; bytes 4-7 are matrix B row-major.
- in_last  in  1  marks byte 7 of a frame.
- in_ready  out  1  sequencer accepts a byte.
- sel_in  out  3  core operand slot select.
- input_val  out  DATA_W  core operand value.
- execute  out  1  one-cycle compute strobe to the core.
- sel_out  out  2  core result select.
- result  in  RES_W  core result for the current sel_out.
- out_valid  out  1  result word valid.
- out_data  out  RES_W  result word. Order is C00, C01, C10, C11.
- out_last  out  1  high with C11.
- out_ready  in  1  downstream accepts a result word.
- busy  out  1  high in every state except LOAD.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset values: all outputs 0, except in_ready=1. State=LOAD, byte counter cnt=0, result index idx=0.
- States: LOAD, FLUSH, EXEC, WAIT, SETUP, DRAIN.
- LOAD:
  - in_ready=1.
  - On handshake: sel_in<=cnt and input_val<=in_data, both registered, visible the next cycle and held until the next write.
  - in_last with cnt<7: frame_err pulse, cnt<=0, stay in LOAD. Bytes already written are simply overwritten by the next frame.
  - cnt==7 with in_last: cnt<=0, go to EXEC.
  - cnt==7 without in_last: frame_err pulse, go to FLUSH.
- FLUSH: in_ready=1. Bytes are accepted and discarded until an in_last handshake, then go to LOAD with cnt=0. The core is not written.
- EXEC: in_ready=0, execute=1 for exactly this one cycle. Load wait counter with EXEC_LAT-1, go to WAIT.
- WAIT: count down. At 0: idx<=0, sel_out<=0, go to SETUP.
- SETUP: one cycle with sel_out stable. At cycle end: out_data<=result, out_valid<=1, out_last<=(idx==3), go to DRAIN.
- DRAIN:
  - out_valid=1; out_data and out_last are held stable while out_ready=0.
  - On handshake with idx<3: out_valid<=0, idx++, sel_out<=idx+1, go to SETUP.
  - On handshake with idx==3: out_valid<=0, out_last<=0, sel_out<=0, go to LOAD.
- Per frame: first out_valid rises 1+EXEC_LAT+1 cycles after EXEC entry. Minimum of 2 cycles per result word.
- in_ready is 0 in EXEC/WAIT/SETUP/DRAIN. No input is buffered, so a new frame starts only after the C11 handshake.
- out_data is passed through unmodified, with no width change. The core guarantees 2*255*255=130050 fits in 17 bits.
- Asynchronous reset mid-frame or mid-drain: immediate return to reset values, with no execute or out_valid glitch.
- Signals driven by this block (execute, in_ready, out_valid) are undefined-free and registered or state-decoded.

Decomposition:
- Shared package mm_pkg holds:
  - state enum (LOAD, FLUSH, EXEC, WAIT, SETUP, DRAIN);
  - constants N_OPERANDS=8 and N_RESULTS=4;
  - DATA_W/RES_W defaults, shared with the core.
- No sub-module. Single FSM with counters; the core is instantiated alongside it at the next level, not inside.

Test Plan:
- Nominal frame 01,02,00,03,03,01,02,01 with in_last on byte 8, core model attached, out_ready=1 → exactly one execute pulse; outputs 7,3,6,3 with out_last on 3; then in_ready=1.
- All bytes FF → four outputs of 130050 (0x1FC02), no truncation.
- Backpressure: out_ready low 5 cycles on each word → out_data/out_last stable while stalled, no word lost or duplicated, sel_out advances only after the handshake.
- in_last on byte 4 → frame_err pulse, no execute; the following good frame produces correct results.
- 10-byte frame with in_last on byte 10 → frame_err at byte 8, bytes 9-10 dropped, no execute; the next frame is processed normally.
- Assert reset during WAIT and again during DRAIN → all outputs at reset values immediately; a subsequent frame gives correct results with no stray out_valid.
